// File: rtl/pulpino_mailbox_ctrl_pkg.sv
// pulpino_mailbox_ctrl_pkg: shared types for the PULPino mailbox.
// Flag bit positions and TX/RX state encodings.
package pulpino_mailbox_ctrl_pkg;

  localparam int MBOX_W             = 8;
  localparam int MBOX_EXT_VALID_BIT = 0;
  localparam int MBOX_EXT_ACK_BIT   = 1;
  localparam int MBOX_ERR_BIT       = 7;
  localparam int MBOX_P_ACK_BIT     = 0;
  localparam int MBOX_P_VALID_BIT   = 1;

  typedef enum logic [2:0] {
    TX_IDLE     = 3'b000,
    TX_SETUP    = 3'b001,
    TX_WAIT_ACK = 3'b010,
    TX_WAIT_REL = 3'b011,
    TX_ERR      = 3'b100
  } tx_state_e;

  typedef enum logic {
    RX_IDLE     = 1'b0,
    RX_WAIT_REL = 1'b1
  } rx_state_e;

  function automatic logic [MBOX_W-1:0] mbox_flags(
    input logic v,
    input logic a,
    input logic e
  );
    logic [MBOX_W-1:0] f;
    f                     = '0;
    f[MBOX_EXT_VALID_BIT] = v;
    f[MBOX_EXT_ACK_BIT]   = a;
    f[MBOX_ERR_BIT]       = e;
    return f;
  endfunction

endpackage

// File: rtl/pulpino_mailbox_ctrl_fifo.sv
// pulpino_mbox_fifo: synchronous FIFO, head word visible on rd_data.
// Push while full succeeds only together with a pop.
module pulpino_mbox_fifo
  import pulpino_mailbox_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  assign rd_data = mem[rd_ptr];
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // pointers wrap naturally; occupancy tracks push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/pulpino_mailbox_ctrl.sv
// pulpino_mailbox_ctrl: host<->PULPino byte mailbox sequencer.
// TX FIFO + 4-phase TX handshake, one-deep RX buffer.
module pulpino_mailbox_ctrl
  import pulpino_mailbox_ctrl_pkg::*;
#(
  parameter int pFIFO_DEPTH = 16,
  parameter int pTIMEOUT    = 1000,
  parameter int pTIMEOUT_W  = 16
) (
  input  logic                         crypto_clk,
  input  logic                         reset_i,
  input  logic                         tx_wr_en,
  input  logic [7:0]                   tx_wr_data,
  output logic                         tx_full,
  output logic [$clog2(pFIFO_DEPTH):0] tx_count,
  output logic [7:0]                   rx_data,
  output logic                         rx_valid,
  input  logic                         rx_rd_en,
  input  logic                         clear_err,
  input  logic [7:0]                   I_pulpino_data,
  input  logic [7:0]                   I_pulpino_flags,
  output logic [7:0]                   O_ext_data,
  output logic [7:0]                   O_ext_flags,
  output logic                         O_busy,
  output logic                         O_timeout,
  output logic                         O_overflow
);

  localparam logic [pTIMEOUT_W-1:0] TMO =
    pTIMEOUT_W'(pTIMEOUT);
  localparam bit TMO_EN = (pTIMEOUT != 0);

  logic p_ack;
  logic p_valid;
  logic unused_flags;

  assign p_ack        = I_pulpino_flags[MBOX_P_ACK_BIT];
  assign p_valid      = I_pulpino_flags[MBOX_P_VALID_BIT];
  assign unused_flags = ^I_pulpino_flags[7:2];

  logic       fifo_rd;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;
  logic       fifo_ne_q;

  pulpino_mbox_fifo #(
    .WIDTH (8),
    .DEPTH (pFIFO_DEPTH)
  ) u_fifo (
    .clk     (crypto_clk),
    .rst     (reset_i),
    .wr_en   (tx_wr_en),
    .wr_data (tx_wr_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (tx_count)
  );

  assign tx_full = fifo_full;

  tx_state_e             tx_state_q, tx_state_d;
  logic [pTIMEOUT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]            ext_data_q, ext_data_d;
  logic                  ext_valid_q, ext_valid_d;
  logic                  tmo_hit;
  logic                  ovf_hit;
  logic                  timeout_q, timeout_d;
  logic                  overflow_q, overflow_d;
  logic                  err_q, err_d;

  rx_state_e  rx_state_q, rx_state_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       ext_ack_q, ext_ack_d;

  assign cnt_inc = cnt_q + 1'b1;

  // TX next-state: pop, present data, raise VALID, await ACK/release
  always_comb begin
    tx_state_d  = tx_state_q;
    cnt_d       = cnt_q;
    ext_data_d  = ext_data_q;
    ext_valid_d = ext_valid_q;
    fifo_rd     = 1'b0;
    tmo_hit     = 1'b0;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (fifo_ne_q && !fifo_empty) begin
          fifo_rd    = 1'b1;
          ext_data_d = fifo_head;
          tx_state_d = TX_SETUP;
        end
      end
      TX_SETUP: begin
        ext_valid_d = 1'b1;
        cnt_d       = '0;
        tx_state_d  = TX_WAIT_ACK;
      end
      TX_WAIT_ACK: begin
        if (p_ack) begin
          ext_valid_d = 1'b0;
          cnt_d       = '0;
          tx_state_d  = TX_WAIT_REL;
        end else if (TMO_EN && cnt_inc == TMO) begin
          tmo_hit     = 1'b1;
          ext_valid_d = 1'b0;
          cnt_d       = '0;
          tx_state_d  = TX_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_WAIT_REL: begin
        if (!p_ack) begin
          cnt_d      = '0;
          tx_state_d = TX_IDLE;
        end else if (TMO_EN && cnt_inc == TMO) begin
          tmo_hit    = 1'b1;
          cnt_d      = '0;
          tx_state_d = TX_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TX_ERR: begin
        if (clear_err) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // sticky errors: a new error wins over clear_err
  always_comb begin
    ovf_hit    = tx_wr_en && fifo_full && !fifo_rd;
    timeout_d  = tmo_hit | (timeout_q & ~clear_err);
    err_d      = tmo_hit | (err_q & ~clear_err);
    overflow_d = ovf_hit | (overflow_q & ~clear_err);
  end

  // RX next-state: capture when buffer free, hold ACK until release
  always_comb begin
    rx_state_d = rx_state_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ext_ack_d  = ext_ack_q;
    if (rx_rd_en && rx_valid_q) rx_valid_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (p_valid && !rx_valid_q) begin
          rx_data_d  = I_pulpino_data;
          rx_valid_d = 1'b1;
          ext_ack_d  = 1'b1;
          rx_state_d = RX_WAIT_REL;
        end
      end
      RX_WAIT_REL: begin
        if (!p_valid) begin
          ext_ack_d  = 1'b0;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX state, counter and error registers
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      tx_state_q  <= TX_IDLE;
      cnt_q       <= '0;
      ext_data_q  <= '0;
      ext_valid_q <= 1'b0;
      fifo_ne_q   <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      cnt_q       <= cnt_d;
      ext_data_q  <= ext_data_d;
      ext_valid_q <= ext_valid_d;
      fifo_ne_q   <= !fifo_empty;
      timeout_q   <= timeout_d;
      overflow_q  <= overflow_d;
      err_q       <= err_d;
    end
  end

  // RX state and capture registers
  always_ff @(posedge crypto_clk) begin
    if (reset_i) begin
      rx_state_q <= RX_IDLE;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ext_ack_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ext_ack_q  <= ext_ack_d;
    end
  end

  assign O_ext_data  = ext_data_q;
  assign O_ext_flags = mbox_flags(ext_valid_q, ext_ack_q, err_q);
  assign O_busy      = (tx_state_q != TX_IDLE) || !fifo_empty;
  assign O_timeout   = timeout_q;
  assign O_overflow  = overflow_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule
